serial_add_sched: RTL
=====================

Name: serial_add_sched

Overview:
- Shares one external `serial_adder` instance between NREQ requesters.
- Each requester submits a full-width operand pair of WORDS*BW bits.
- The block arbitrates round-robin, latches the winner's operands and streams them LSB chunk first through the adder, one BW-bit chunk per cycle. It drives the adder's carry-clear (`reset` pin) and reassembles the registered chunk results into a full-width sum tagged with the requester ID.
- It sits between the accumulation engines and the bit/digit-serial arithmetic datapath.

Parameters:
- BW, 16, chunk width; must match the adder's BW.
- WORDS, 4, chunks per operand (>=1); operand width W = WORDS*BW.
- NREQ, 4, number of requesters (>=1).
- IDW, max(1,$clog2(NREQ)), derived localparam: requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester level request; the requester holds operands stable while req is high.
- req_a  in  NREQ*W  operand A of requester i at [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- ack  out  NREQ  one-hot, combinational; high in the grant cycle, operands latched at the end of it.
- sa_clr  out  1  to the adder `reset` pin (carry preset).
- sa_a  out  BW  to adder `a`.
- sa_b  out  BW  to adder `b`.
- sa_c  in  BW  from adder `c` (registered inside the adder).
- busy  out  1  high while any chunk is in flight or being assembled.
- done  out  1  one-cycle pulse: done_sum/done_id valid.
- done_id  out  IDW  requester ID of the completed sum.
- done_sum  out  W  assembled result, chunk k at [k*BW +: BW].

Behaviour:
- Reset (async): FSM=IDLE, ack=0, done=0, done_id=0, done_sum=0, busy=0, sa_a=sa_b=0, RR pointer "last granted"=NREQ-1 (requester 0 wins first).
- sa_clr = reset | grant. The adder therefore sees its carry preset during reset and during every grant cycle.
- FSM has two states:
  - IDLE: grant is allowed.
  - STREAM: carries a chunk counter k = 0..WORDS-1.
- Grant is allowed in IDLE, or in STREAM when k == WORDS-1 (last chunk cycle). This gives back-to-back operation with no bubble, because the adder carry preset lands on the cycle after the last chunk.
- Arbitration: the first requester with req high, searching upward (mod NREQ) from last granted + 1. The pointer updates only on grant.
- Grant cycle g:
  - ack[i]=1.
  - req_a[i]/req_b[i] are latched into internal shift registers; the ID is latched.
  - FSM -> STREAM with k=0.
- Cycle g+1+k: sa_a/sa_b = chunk k, driven from a register (no combinational path from req_*).
- Cycle g+2+k: sa_c = sum chunk k. The block captures it using a one-cycle-delayed tag pipe (valid, last, id).
- Cycle g+WORDS+2: done=1, done_sum/done_id valid. done_sum holds its value until the next done.
- Latency from ack to done = WORDS+2 cycles. Throughput is one operation per WORDS cycles.
- Arithmetic:
  - With adder neg_b=0: done_sum = (A+B) mod 2^W.
  - With adder neg_b=1: done_sum = (A-B) mod 2^W.
  - The final carry-out is discarded; there is no overflow flag.
- End of stream: if no request is pending at the last chunk, FSM -> IDLE. sa_a/sa_b are driven to 0 in IDLE.
- WORDS=1: grant is possible every cycle and sa_clr stays high continuously. This is legal because the preset affects only the next cycle's carry.
- A requester that drops req before ack loses nothing; the pointer is unchanged.
- Async reset mid-operation aborts all in-flight chunks. No done is issued for them.
- busy = (state==STREAM) | tag-pipe valid | assembly pending.

Decomposition:
- Package `serial_add_pkg` holds:
  - the state enum (IDLE, STREAM);
  - a function `clog2_min1`;
  - packing helper functions for chunk k of a W-bit vector.
- One sub-module: `rr_arbiter` (NREQ-wide, pointer and one-hot grant, enable input). It is reusable elsewhere.
- Shift registers, the tag pipe and the assembler stay inline.

Test Plan:
- Single add: BW=16, WORDS=4, neg_b=0, req[0], A=0x0000_FFFF_FFFF_FFFF, B=1 -> ack[0] at cycle g, done at g+6, done_sum=0x0001_0000_0000_0000, done_id=0. This checks carry propagation across chunks.
- Round-robin: req=4'b1111 held, with the operand pair for each requester i given by A=i, B=0x10 -> grants in order 0,1,2,3,0, each 4 cycles apart. done_sum values 0x10,0x11,0x12,0x13, done_id in the same order, with no idle cycle between them.
- Carry isolation: back-to-back A=all-ones, B=1 then A=0, B=0 -> first sum 0, second sum 0. This proves the carry preset on the shared cycle.
- Subtract: adder neg_b=1, A=5, B=7 -> done_sum = 2^64-2 (0xFFFF_FFFF_FFFF_FFFE).
- Reset mid-stream: assert reset at g+2 for 1 cycle -> all outputs 0 immediately, no done. The next request completes correctly, with requester 0 having priority.
- WORDS=1, BW=8: req[1] held continuously, A=0xFF, B=0x01 -> ack every cycle, done every cycle from g+3, done_sum=0x00 each time.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the time-shared serial adder scheduler.
package serial_add_pkg;

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit offset of chunk k in a vector packed as back-to-back bw-bit chunks.
  function automatic int chunk_lo(input int k, input int bw);
    return k * bw;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
);

  logic [IDW-1:0] last;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(last) + 1 + i) % NREQ);
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last <= IDW'(NREQ - 1);
    else if (gnt_valid) last <= gnt_id;
  end

endmodule

// File: rtl/serial_add_sched.sv
// Streams arbitrated operand pairs LSB chunk first through one shared
// serial adder and reassembles the registered chunk sums.
module serial_add_sched import serial_add_pkg::*; #(
  parameter int   BW    = 16,
  parameter int   WORDS = 4,
  parameter int   NREQ  = 4,
  localparam int  W     = WORDS * BW,
  localparam int  IDW   = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   ack,
  output logic              sa_clr,
  output logic [BW-1:0]     sa_a,
  output logic [BW-1:0]     sa_b,
  input  logic [BW-1:0]     sa_c,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [W-1:0]      done_sum
);

  localparam int KW = clog2_min1(WORDS);

  state_t          state;
  logic [KW-1:0]   k;
  logic            last_k;
  logic            grant_en;
  logic            grant;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  cur_id;
  logic [W-1:0]    op_a, op_b;
  logic [W-1:0]    sh_a, sh_b;
  logic            tag_v, tag_last;
  logic [IDW-1:0]  tag_id;
  logic            asm_pend;
  logic [W-1:0]    asm_buf;
  logic [W+BW-1:0] asm_cat;

  assign last_k   = (k == KW'(WORDS - 1));
  // A grant on the last chunk lets the next stream follow with no bubble.
  assign grant_en = !reset && ((state == IDLE) || last_k);
  assign sa_clr   = reset | grant;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (grant_en),
    .req       (req),
    .gnt       (ack),
    .gnt_id    (gnt_id),
    .gnt_valid (grant)
  );

  assign op_a = req_a[chunk_lo(int'(gnt_id), W) +: W];
  assign op_b = req_b[chunk_lo(int'(gnt_id), W) +: W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      cur_id <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      sa_a   <= '0;
      sa_b   <= '0;
    end else if (grant) begin
      state  <= STREAM;
      k      <= '0;
      cur_id <= gnt_id;
      sa_a   <= op_a[BW-1:0];
      sa_b   <= op_b[BW-1:0];
      sh_a   <= op_a >> BW;
      sh_b   <= op_b >> BW;
    end else if (state == STREAM) begin
      if (last_k) begin
        state <= IDLE;
        k     <= '0;
        sa_a  <= '0;
        sa_b  <= '0;
      end else begin
        k    <= k + 1'b1;
        sa_a <= sh_a[BW-1:0];
        sa_b <= sh_b[BW-1:0];
        sh_a <= sh_a >> BW;
        sh_b <= sh_b >> BW;
      end
    end
  end

  // Each chunk sum enters at the top; after WORDS shifts the word is aligned.
  assign asm_cat = {sa_c, asm_buf};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v    <= 1'b0;
      tag_last <= 1'b0;
      tag_id   <= '0;
      asm_pend <= 1'b0;
      asm_buf  <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      done_sum <= '0;
    end else begin
      tag_v    <= (state == STREAM);
      tag_last <= (state == STREAM) && last_k;
      tag_id   <= cur_id;
      done     <= tag_v && tag_last;
      if (tag_v) begin
        asm_buf  <= asm_cat[W+BW-1:BW];
        asm_pend <= !tag_last;
        if (tag_last) begin
          done_sum <= asm_cat[W+BW-1:BW];
          done_id  <= tag_id;
        end
      end
    end
  end

  assign busy = (state == STREAM) | tag_v | asm_pend;

endmodule
